// File: rtl/wt_cache_pkg.sv
// Shared constants and helpers for the write-through cache memory arbiter.
package wt_cache_pkg;

  localparam int unsigned WT_ARB_DEF_MAX_OUTSTANDING = 4;

  function automatic int unsigned wt_arb_idx_w(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wt_rr_arb.sv
// N-input request picker producing a one-hot grant plus index.
// Round-robin by default; WT_MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 highest).
module wt_rr_arb
  import wt_cache_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = wt_arb_idx_w(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic            w_vld;
  logic [IdxW-1:0] w_idx;

`ifdef WT_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_vld = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_vld && req_i[i]) begin
        w_vld = 1'b1;
        w_idx = i[IdxW-1:0];
      end
    end
  end
`else
  logic [IdxW-1:0] r_ptr;

  // Scan starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    int unsigned j;
    j     = 0;
    w_vld = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (!w_vld && req_i[j]) begin
        w_vld = 1'b1;
        w_idx = j[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (en_i && w_vld) begin
      r_ptr <= (w_idx == IdxW'(N - 1)) ? '0 : w_idx + IdxW'(1);
    end
  end
`endif

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_o[i] = en_i && w_vld && (w_idx == i[IdxW-1:0]);
    end
  end

  assign idx_o = w_idx;

endmodule

// File: rtl/wt_mem_arbiter.sv
// NumPorts cache clients sharing one memory port, with per-port outstanding limits and
// tag-based return routing. Define WT_MEM_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter  int unsigned NumPorts       = 2,
  parameter  int unsigned ReqWidth       = 128,
  parameter  int unsigned RtrnWidth      = 128,
  parameter  int unsigned TidWidth       = 2,
  parameter  int unsigned MaxOutstanding = WT_ARB_DEF_MAX_OUTSTANDING,
  localparam int unsigned PortIdxW       = wt_arb_idx_w(NumPorts),
  localparam int unsigned TagW           = PortIdxW + TidWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  output logic                         busy_o,
  output logic                         err_o,
  input  logic [NumPorts-1:0]          port_req_i,
  output logic [NumPorts-1:0]          port_ack_o,
  input  logic [NumPorts*ReqWidth-1:0] port_data_i,
  input  logic [NumPorts*TidWidth-1:0] port_tid_i,
  output logic [NumPorts-1:0]          port_rtrn_vld_o,
  output logic [RtrnWidth-1:0]         port_rtrn_o,
  output logic [TidWidth-1:0]          port_rtrn_tid_o,
  output logic                         mem_req_o,
  input  logic                         mem_ack_i,
  output logic [ReqWidth-1:0]          mem_data_o,
  output logic [TagW-1:0]              mem_tid_o,
  input  logic                         mem_rtrn_vld_i,
  input  logic [RtrnWidth-1:0]         mem_rtrn_i,
  input  logic [TagW-1:0]              mem_rtrn_tid_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [NumPorts-1:0][CntW-1:0] r_cnt;
  logic                          r_req_vld;
  logic [ReqWidth-1:0]           r_data;
  logic [TagW-1:0]               r_tid;
  logic [NumPorts-1:0]           r_rtrn_vld;
  logic [RtrnWidth-1:0]          r_rtrn;
  logic [TidWidth-1:0]           r_rtrn_tid;
  logic                          r_err;

  logic                          w_ld;
  logic [NumPorts-1:0]           w_elig;
  logic [NumPorts-1:0]           w_gnt;
  logic [PortIdxW-1:0]           w_gnt_idx;
  logic [ReqWidth-1:0]           w_gnt_data;
  logic [TidWidth-1:0]           w_gnt_tid;
  logic [PortIdxW-1:0]           w_rt_idx;
  logic [NumPorts-1:0]           w_rtrn_sel;
  logic                          w_rt_err;

  assign w_ld = !rst_i && !stall_i && (!r_req_vld || mem_ack_i);

  // A returned credit is only reusable once the response has been handed to the client,
  // so the port stays blocked while its return output is valid.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < NumPorts; p++) begin
      w_elig[p] = port_req_i[p] &&
                  (({1'b0, r_cnt[p]} + {{CntW{1'b0}}, r_rtrn_vld[p]}) < (CntW+1)'(MaxOutstanding));
    end
  end

  wt_rr_arb #(
    .N    (NumPorts),
    .IdxW (PortIdxW)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (w_ld),
    .req_i (w_elig),
    .gnt_o (w_gnt),
    .idx_o (w_gnt_idx)
  );

  always_comb begin
    w_gnt_data = '0;
    w_gnt_tid  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (w_gnt[p]) begin
        w_gnt_data = port_data_i[p*ReqWidth +: ReqWidth];
        w_gnt_tid  = port_tid_i[p*TidWidth +: TidWidth];
      end
    end
  end

  assign w_rt_idx = mem_rtrn_tid_i[TagW-1 -: PortIdxW];

  // Out-of-range indices match no port, so they fall through to the error path.
  always_comb begin
    w_rtrn_sel = '0;
    for (int p = 0; p < NumPorts; p++) begin
      w_rtrn_sel[p] = mem_rtrn_vld_i && (w_rt_idx == p[PortIdxW-1:0]) && (r_cnt[p] != '0);
    end
  end

  assign w_rt_err = mem_rtrn_vld_i && !(|w_rtrn_sel);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_req_vld  <= 1'b0;
      r_data     <= '0;
      r_tid      <= '0;
      r_rtrn_vld <= '0;
      r_rtrn     <= '0;
      r_rtrn_tid <= '0;
      r_err      <= 1'b0;
    end else begin
      if (|w_gnt) begin
        r_req_vld <= 1'b1;
        r_data    <= w_gnt_data;
        r_tid     <= {w_gnt_idx, w_gnt_tid};
      end else if (mem_ack_i) begin
        r_req_vld <= 1'b0;
      end
      r_rtrn_vld <= w_rtrn_sel;
      if (|w_rtrn_sel) begin
        r_rtrn     <= mem_rtrn_i;
        r_rtrn_tid <= mem_rtrn_tid_i[TidWidth-1:0];
      end
      if (w_rt_err) r_err <= 1'b1;
      for (int p = 0; p < NumPorts; p++) begin
        case ({w_gnt[p], w_rtrn_sel[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + CntW'(1);
          2'b01:   r_cnt[p] <= r_cnt[p] - CntW'(1);
          default: r_cnt[p] <= r_cnt[p];
        endcase
      end
    end
  end

  assign port_ack_o      = w_gnt;
  assign mem_req_o       = r_req_vld;
  assign mem_data_o      = r_data;
  assign mem_tid_o       = r_tid;
  assign port_rtrn_vld_o = r_rtrn_vld;
  assign port_rtrn_o     = r_rtrn;
  assign port_rtrn_tid_o = r_rtrn_tid;
  assign err_o           = r_err;
  assign busy_o          = r_req_vld || (|r_cnt);

endmodule
